// File: rtl/alu_pkg.sv
// Shared ALU definitions: FunSel codes, flag bit positions and
// the sequencer state encoding.
package alu_pkg;

  localparam int ALU_DATA_W   = 16;
  localparam int ALU_FLAG_W   = 4;
  localparam int ALU_REPEAT_W = 4;
  localparam int ALU_FS_W     = 5;

  // bit4 selects 16-bit operation, bit4=0 is the 8-bit variant
  localparam logic [4:0] FS_ADD8  = 5'b00100;
  localparam logic [4:0] FS_ADC8  = 5'b00101;
  localparam logic [4:0] FS_SUB8  = 5'b00110;
  localparam logic [4:0] FS_XOR8  = 5'b01001;
  localparam logic [4:0] FS_LSL8  = 5'b01011;
  localparam logic [4:0] FS_LSR8  = 5'b01100;
  localparam logic [4:0] FS_ADD16 = 5'b10100;
  localparam logic [4:0] FS_ADC16 = 5'b10101;
  localparam logic [4:0] FS_SUB16 = 5'b10110;
  localparam logic [4:0] FS_XOR16 = 5'b11001;
  localparam logic [4:0] FS_LSL16 = 5'b11011;
  localparam logic [4:0] FS_LSR16 = 5'b11100;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPTURE,
    RESP
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Runs one ALU FunSel for 1..16 iterations, feeding ALUOut back
// into A, and returns the final result and flags.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W   = ALU_DATA_W,
  parameter int FLAG_W   = ALU_FLAG_W,
  parameter int REPEAT_W = ALU_REPEAT_W
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_funsel,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic [REPEAT_W-1:0] req_repeat,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic [FLAG_W-1:0]   rsp_flags,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [4:0]          alu_funsel,
  output logic                alu_wf,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic [FLAG_W-1:0]   alu_flags,
  output logic                busy
);

  seq_state_t          state;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   res_q;
  logic [4:0]          fs_q;
  logic [FLAG_W-1:0]   flags_q;
  logic [REPEAT_W-1:0] count;
  logic                ready_q;
  logic                valid_q;
  logic                wf_q;
  logic                busy_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      acc     <= '0;
      b_q     <= '0;
      fs_q    <= '0;
      count   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      wf_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            acc     <= req_a;
            b_q     <= req_b;
            fs_q    <= req_funsel;
            count   <= req_repeat;
            ready_q <= 1'b0;
            wf_q    <= 1'b1;
            busy_q  <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          acc <= alu_out;
          if (count == '0) begin
            wf_q  <= 1'b0;
            state <= CAPTURE;
          end else begin
            count <= count - 1'b1;
          end
        end
        CAPTURE: begin
          // flags were written by the last EXEC edge
          res_q   <= acc;
          flags_q <= alu_flags;
          valid_q <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  // reset forces every output low in the same cycle
  assign req_ready  = ~Reset & ready_q;
  assign rsp_valid  = ~Reset & valid_q;
  assign alu_wf     = ~Reset & wf_q;
  assign busy       = ~Reset & busy_q;
  assign rsp_result = Reset ? '0 : res_q;
  assign rsp_flags  = Reset ? '0 : flags_q;
  assign alu_a      = Reset ? '0 : acc;
  assign alu_b      = Reset ? '0 : b_q;
  assign alu_funsel = Reset ? '0 : fs_q;

endmodule
